fm_op_sequencer: RTL and testbench
==================================

Name: fm_op_sequencer

Overview:
- Time-multiplexes the single FM phase datapath across NUM_OPS operator slots once per audio sample.
- On each sample tick, walks op_sel 0..NUM_OPS-1 with a fixed slot cadence. Strobes the parameter register file, then the phase unit's next/restart inputs.
- Holds per-operator key-on (phase restart) requests posted by the register interface and applies each exactly once, on that operator's next update.

Parameters:
NUM_OPS, 36, operator slots per frame (1..64; op_sel is 6 bits)
SLOT_CYCLES, 4, clocks per operator slot (>= 3)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
sample_tick  input  1  one-cycle pulse; start of a new sample frame
keyon_set  input  1  one-cycle pulse; post a restart request for keyon_op
keyon_op  input  6  operator index for keyon_set
overrun_clr  input  1  clears sticky overrun flag
op_sel  output  6  current operator index to phase unit and parameter RAM
param_rd_en  output  1  parameter RAM read strobe for op_sel
next  output  1  one-cycle phase-accumulator write strobe
restart  output  1  zero the phase of op_sel; valid only while next=1
busy  output  1  frame in progress
frame_done  output  1  one-cycle pulse after the last operator is updated
overrun  output  1  sticky; sample_tick arrived while busy

Behaviour:
- Reset (async, reset_n=0): state IDLE; op_sel=0, param_rd_en=0, next=0, restart=0, busy=0, frame_done=0, overrun=0; all pending restart flags cleared; slot counter cleared. Reset mid-frame abandons the frame with no further next pulses.
- State machine has four states: IDLE, FETCH, SETTLE and ISSUE.
  - IDLE: busy=0. sample_tick=1 -> FETCH with op_sel=0.
  - FETCH (1 cycle): busy=1, param_rd_en=1.
  - SETTLE (SLOT_CYCLES-2 cycles): parameters stable. The counter counts down, then the state moves to ISSUE.
  - ISSUE (1 cycle): next=1, restart=pending[op_sel]. If op_sel<NUM_OPS-1: op_sel+1 -> FETCH. Otherwise op_sel returns to 0, the state goes to IDLE, and frame_done=1 on the following cycle (busy=0 that cycle).
- Timing: a tick at cycle T gives the first FETCH at T+1 and the op k ISSUE at T+(k+1)*SLOT_CYCLES. frame_done is at T+NUM_OPS*SLOT_CYCLES+1, which is T+145 at defaults.
- op_sel is constant for the full slot and changes only on the cycle after ISSUE.
- A sample_tick in any non-IDLE state, including the last ISSUE, is dropped and sets overrun. A tick in the frame_done cycle is accepted normally.
- overrun_clr clears overrun. If a set and a clear occur in the same cycle, the set wins.
- Pending flags (NUM_OPS bits):
  - keyon_set sets pending[keyon_op].
  - keyon_op >= NUM_OPS is ignored.
  - ISSUE of op k clears pending[k].
  - If keyon_set targets k in the same cycle as ISSUE of k, the current restart uses the old value and pending[k] ends set; the set wins.
  - Repeated keyon_set before service collapses to one restart.
  - Requests posted while IDLE persist until the next frame.
- restart=0 whenever next=0.
- No arithmetic beyond the slot counter (ceil(log2 SLOT_CYCLES) bits) and the 6-bit op_sel increment. op_sel never exceeds NUM_OPS-1.

Test Plan:
- Reset, then a single sample_tick at cycle 10 -> 36 next pulses at cycles 14,18,...,154; op_sel sequence 0..35; frame_done at cycle 155; busy high on cycles 11..154; restart never asserted.
- keyon_set op 5 while IDLE, then tick -> restart=1 only on op 5's ISSUE (T+24); a second frame has no restart on op 5.
- keyon_set op 7 on the exact cycle of op 7's ISSUE with pending clear -> restart=0 that cycle; restart=1 on op 7 in the next frame.
- sample_tick at T+50 during a frame -> overrun=1, frame completes unchanged with frame_done at T+145. overrun_clr coincident with another mid-frame tick -> overrun stays 1. A lone overrun_clr -> 0.
- keyon_op=40 with keyon_set -> no restart on any operator. Tick coincident with frame_done -> new frame starts the next cycle, no overrun.
- reset_n low at T+60 for 2 cycles -> all outputs 0 immediately; posted pending flags are lost; the next tick restarts at op_sel=0.

Source files
------------

// File: rtl/fm_op_sequencer.sv
// ----------------------------------------------------------------------------
// fm_op_sequencer
//
// Purpose:
//   Shares one FM phase datapath across NUM_OPS operator slots per sample.
//   Each sample_tick starts a frame that visits op_sel = 0 .. NUM_OPS-1. Every
//   operator slot is SLOT_CYCLES clocks long:
//     FETCH  (1 cycle)              parameter RAM read strobe for op_sel
//     SETTLE (SLOT_CYCLES-2 cycles) parameters settle at the phase unit
//     ISSUE  (1 cycle)              phase accumulator write strobe
//   Key-on requests from the register interface are held per operator. Each
//   one becomes a single restart on that operator's next ISSUE.
//
// Ports:
//   clk          in   system clock
//   reset_n      in   asynchronous active-low reset
//   sample_tick  in   one-cycle pulse, start of a new sample frame
//   keyon_set    in   one-cycle pulse, post a restart request for keyon_op
//   keyon_op     in   operator index for keyon_set (>= NUM_OPS is ignored)
//   overrun_clr  in   clears the sticky overrun flag
//   op_sel       out  current operator index to phase unit / parameter RAM
//   param_rd_en  out  parameter RAM read strobe for op_sel
//   next         out  one-cycle phase accumulator write strobe
//   restart      out  zero the phase of op_sel, only asserted with next
//   busy         out  frame in progress
//   frame_done   out  one-cycle pulse on the cycle after the last ISSUE
//   overrun      out  sticky, sample_tick arrived while busy
// ----------------------------------------------------------------------------
module fm_op_sequencer #(
    parameter int unsigned NUM_OPS     = 36,
    parameter int unsigned SLOT_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sample_tick,
    input  logic       keyon_set,
    input  logic [5:0] keyon_op,
    input  logic       overrun_clr,
    output logic [5:0] op_sel,
    output logic       param_rd_en,
    output logic       next,
    output logic       restart,
    output logic       busy,
    output logic       frame_done,
    output logic       overrun
);

    // Slot counter only has to hold SLOT_CYCLES-3 (the SETTLE countdown).
    localparam int unsigned CntW = (SLOT_CYCLES > 2) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [CntW-1:0] SettleLoad = CntW'(SLOT_CYCLES - 3);
    localparam logic [CntW-1:0] CntOne     = CntW'(1);
    localparam logic [5:0]      LastOp     = 6'(NUM_OPS - 1);
    localparam logic [5:0]      OpOne      = 6'd1;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StSettle,
        StIssue
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CntW-1:0]    r_cnt;
    logic [CntW-1:0]    w_cnt_nxt;
    logic [5:0]         r_op_sel;
    logic [5:0]         w_op_sel_nxt;
    logic [NUM_OPS-1:0] r_pending;
    logic [NUM_OPS-1:0] w_pending_nxt;
    logic               r_frame_done;
    logic               w_frame_done_nxt;
    logic               r_overrun;
    logic               w_overrun_nxt;
    logic               w_issue;
    logic               w_pend_sel;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= StIdle;
            r_cnt        <= '0;
            r_op_sel     <= '0;
            r_pending    <= '0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_op_sel     <= w_op_sel_nxt;
            r_pending    <= w_pending_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_overrun    <= w_overrun_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic and slot strobes
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_op_sel_nxt     = r_op_sel;
        w_frame_done_nxt = 1'b0;
        busy             = 1'b0;
        param_rd_en      = 1'b0;
        w_issue          = 1'b0;

        case (r_state)
            StIdle: begin
                if (sample_tick) begin
                    w_state_nxt  = StFetch;
                    w_op_sel_nxt = '0;
                end
            end

            StFetch: begin
                busy        = 1'b1;
                param_rd_en = 1'b1;
                w_cnt_nxt   = SettleLoad;
                w_state_nxt = StSettle;
            end

            StSettle: begin
                busy = 1'b1;
                if (r_cnt == '0) begin
                    w_state_nxt = StIssue;
                end else begin
                    w_cnt_nxt = r_cnt - CntOne;
                end
            end

            StIssue: begin
                busy    = 1'b1;
                w_issue = 1'b1;
                if (r_op_sel == LastOp) begin
                    // Last operator: back to idle; frame_done lands next cycle,
                    // where a fresh tick is already accepted.
                    w_op_sel_nxt     = '0;
                    w_state_nxt      = StIdle;
                    w_frame_done_nxt = 1'b1;
                end else begin
                    w_op_sel_nxt = r_op_sel + OpOne;
                    w_state_nxt  = StFetch;
                end
            end

            default: begin
                w_state_nxt  = StIdle;
                w_op_sel_nxt = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Pending restart flags
    // ------------------------------------------------------------------------
    // Select the pending bit of the operator being issued. The loop form keeps
    // the index within NUM_OPS regardless of the 6-bit op_sel width.
    always_comb begin
        w_pend_sel = 1'b0;
        for (int i = 0; i < NUM_OPS; i++) begin
            if (r_op_sel == 6'(i)) begin
                w_pend_sel = r_pending[i];
            end
        end
    end

    // Service clears first, a same-cycle post then re-sets the bit, so a
    // request landing on its own ISSUE survives to the next frame. Indices
    // at or above NUM_OPS match no bit and are dropped.
    always_comb begin
        w_pending_nxt = r_pending;
        for (int i = 0; i < NUM_OPS; i++) begin
            if (w_issue && (r_op_sel == 6'(i))) begin
                w_pending_nxt[i] = 1'b0;
            end
            if (keyon_set && (keyon_op == 6'(i))) begin
                w_pending_nxt[i] = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Sticky overrun: a tick outside IDLE is dropped and flagged; set beats clear.
    // ------------------------------------------------------------------------
    always_comb begin
        w_overrun_nxt = r_overrun;
        if (sample_tick && (r_state != StIdle)) begin
            w_overrun_nxt = 1'b1;
        end else if (overrun_clr) begin
            w_overrun_nxt = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    always_comb begin
        next       = w_issue;
        restart    = w_issue & w_pend_sel;
        op_sel     = r_op_sel;
        frame_done = r_frame_done;
        overrun    = r_overrun;
    end

    // ------------------------------------------------------------------------
    // Structural invariants
    // ------------------------------------------------------------------------
    a_restart_needs_next : assert property (
        @(posedge clk) disable iff (!reset_n) restart |-> next
    );

    a_op_sel_range : assert property (
        @(posedge clk) disable iff (!reset_n) op_sel <= LastOp
    );

    a_op_sel_stable_in_slot : assert property (
        @(posedge clk) disable iff (!reset_n)
        (busy && !next) |=> (op_sel == $past(op_sel))
    );

endmodule

// File: tb/tb_fm_op_sequencer.sv
// ----------------------------------------------------------------------------
// tb_fm_op_sequencer
//
// Directed bench for fm_op_sequencer. A frame model describes every output as
// a function of the cycle distance from the accepted sample_tick, plus a
// pending-request bitmap and an overrun flag. The single driver process checks
// the DUT against that model on every negedge and adds hand-computed literal
// expectations at key cycles.
// ----------------------------------------------------------------------------
module tb_fm_op_sequencer;

    localparam int N = 36;
    localparam int S = 4;

    logic       clk         = 1'b0;
    logic       reset_n     = 1'b0;
    logic       sample_tick = 1'b0;
    logic       keyon_set   = 1'b0;
    logic [5:0] keyon_op    = 6'd0;
    logic       overrun_clr = 1'b0;
    logic [5:0] op_sel;
    logic       param_rd_en;
    logic       next;
    logic       restart;
    logic       busy;
    logic       frame_done;
    logic       overrun;

    always #5 clk = ~clk;

    fm_op_sequencer #(
        .NUM_OPS     (N),
        .SLOT_CYCLES (S)
    ) u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sample_tick (sample_tick),
        .keyon_set   (keyon_set),
        .keyon_op    (keyon_op),
        .overrun_clr (overrun_clr),
        .op_sel      (op_sel),
        .param_rd_en (param_rd_en),
        .next        (next),
        .restart     (restart),
        .busy        (busy),
        .frame_done  (frame_done),
        .overrun     (overrun)
    );

    int n_cmp      = 0;
    int n_bad      = 0;
    int mcyc       = 0;   // index of the current clock cycle
    int t_start    = -1;  // cycle of the last accepted sample_tick
    bit pend [64];
    bit ovr        = 1'b0;
    int n_next_seen = 0;
    int n_rst_seen  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d at cycle %0d", name, act, exp, mcyc);
        end
    endtask

    // Expected outputs for the current cycle, then advance the model with the
    // inputs held during this cycle.
    task automatic model_cycle();
        int d;
        bit inb;
        int e_op;
        bit e_rd;
        bit e_nx;
        bit e_rs;
        bit e_fd;
        d    = (t_start < 0) ? -1 : (mcyc - t_start);
        inb  = (d >= 1) && (d <= N * S);
        e_op = inb ? (d - 1) / S : 0;
        e_rd = inb && (((d - 1) % S) == 0);
        e_nx = inb && ((d % S) == 0);
        e_rs = e_nx && pend[e_op];
        e_fd = (d == N * S + 1);
        if (!reset_n) begin
            inb     = 1'b0;
            e_op    = 0;
            e_rd    = 1'b0;
            e_nx    = 1'b0;
            e_rs    = 1'b0;
            e_fd    = 1'b0;
            t_start = -1;
            ovr     = 1'b0;
            for (int i = 0; i < 64; i++) pend[i] = 1'b0;
        end
        chk("m_op_sel", int'(op_sel), e_op);
        chk("m_param_rd_en", int'(param_rd_en), int'(e_rd));
        chk("m_next", int'(next), int'(e_nx));
        chk("m_restart", int'(restart), int'(e_rs));
        chk("m_busy", int'(busy), int'(inb));
        chk("m_frame_done", int'(frame_done), int'(e_fd));
        chk("m_overrun", int'(overrun), int'(ovr));
        n_next_seen += int'(next);
        n_rst_seen  += int'(restart);
        if (reset_n) begin
            if (e_nx) pend[e_op] = 1'b0;
            if (keyon_set && (int'(keyon_op) < N)) pend[keyon_op] = 1'b1;
            if (sample_tick && inb) ovr = 1'b1;
            else if (overrun_clr) ovr = 1'b0;
            if (sample_tick && !inb) t_start = mcyc;
        end
        mcyc++;
    endtask

    // Inputs change 1 time unit after posedge; the model samples at negedge.
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            model_cycle();
            @(posedge clk);
            #1;
        end
    endtask

    // Full frame from a tick: returns at tick cycle + 146.
    task automatic run_frame();
        sample_tick = 1'b1;
        step(1);
        sample_tick = 1'b0;
        step(N * S + 1);
    endtask

    initial begin
        int t;
        int nx0;
        int rs0;

        step(3);
        reset_n = 1'b1;
        step(6);

        // ---- Single frame: cadence, op_sel walk, frame_done timing ----
        t   = mcyc;
        nx0 = n_next_seen;
        rs0 = n_rst_seen;
        chk("t1_idle_busy", int'(busy), 0);
        sample_tick = 1'b1;
        step(1);
        sample_tick = 1'b0;
        chk("t1_fetch_busy", int'(busy), 1);
        chk("t1_fetch_rd", int'(param_rd_en), 1);
        chk("t1_fetch_next", int'(next), 0);
        step(3);                                 // t+4
        chk("t1_first_next", int'(next), 1);
        chk("t1_first_op", int'(op_sel), 0);
        step(1);                                 // t+5
        chk("t1_op1_fetch_op", int'(op_sel), 1);
        chk("t1_op1_fetch_rd", int'(param_rd_en), 1);
        step(139);                               // t+144
        chk("t1_last_next", int'(next), 1);
        chk("t1_last_op", int'(op_sel), 35);
        chk("t1_last_busy", int'(busy), 1);
        step(1);                                 // t+145
        chk("t1_frame_done", int'(frame_done), 1);
        chk("t1_fd_busy", int'(busy), 0);
        chk("t1_fd_op", int'(op_sel), 0);
        step(1);                                 // t+146
        chk("t1_fd_pulse_end", int'(frame_done), 0);
        chk("t1_next_count", n_next_seen - nx0, 36);
        chk("t1_restart_count", n_rst_seen - rs0, 0);

        // ---- Key-on op 5 while idle, applied exactly once ----
        keyon_set = 1'b1;
        keyon_op  = 6'd5;
        step(1);
        keyon_set = 1'b0;
        step(2);
        rs0 = n_rst_seen;
        t   = mcyc;
        sample_tick = 1'b1;
        step(1);
        sample_tick = 1'b0;
        step(23);                                // t+24
        chk("t2_op5_next", int'(next), 1);
        chk("t2_op5_sel", int'(op_sel), 5);
        chk("t2_op5_restart", int'(restart), 1);
        step(122);                               // t+146
        chk("t2_restart_count", n_rst_seen - rs0, 1);
        rs0 = n_rst_seen;
        run_frame();
        chk("t2_second_frame_restarts", n_rst_seen - rs0, 0);

        // ---- Key-on op 7 on op 7's own ISSUE: deferred to next frame ----
        t = mcyc;
        sample_tick = 1'b1;
        step(1);
        sample_tick = 1'b0;
        step(31);                                // t+32
        keyon_set = 1'b1;
        keyon_op  = 6'd7;
        chk("t3_op7_next", int'(next), 1);
        chk("t3_op7_sel", int'(op_sel), 7);
        chk("t3_op7_restart_old", int'(restart), 0);
        step(1);
        keyon_set = 1'b0;
        step(113);                               // t+146
        t = mcyc;
        sample_tick = 1'b1;
        step(1);
        sample_tick = 1'b0;
        step(31);                                // t+32
        chk("t3_op7_restart_new", int'(restart), 1);
        chk("t3_op7_sel_new", int'(op_sel), 7);
        step(114);                               // t+146

        // ---- Overrun: mid-frame tick, set beats clear, lone clear ----
        t = mcyc;
        sample_tick = 1'b1;
        step(1);
        sample_tick = 1'b0;
        step(49);                                // t+50
        sample_tick = 1'b1;
        step(1);                                 // t+51
        sample_tick = 1'b0;
        chk("t4_overrun_set", int'(overrun), 1);
        chk("t4_op_unchanged", int'(op_sel), 12);
        step(29);                                // t+80
        sample_tick = 1'b1;
        overrun_clr = 1'b1;
        step(1);                                 // t+81
        sample_tick = 1'b0;
        overrun_clr = 1'b0;
        chk("t4_set_beats_clr", int'(overrun), 1);
        step(64);                                // t+145
        chk("t4_frame_done", int'(frame_done), 1);
        step(1);                                 // t+146
        overrun_clr = 1'b1;
        step(1);
        overrun_clr = 1'b0;
        chk("t4_overrun_cleared", int'(overrun), 0);

        // ---- Out-of-range key-on; tick on the frame_done cycle ----
        keyon_set = 1'b1;
        keyon_op  = 6'd40;
        step(1);
        keyon_set = 1'b0;
        rs0 = n_rst_seen;
        t   = mcyc;
        sample_tick = 1'b1;
        step(1);
        sample_tick = 1'b0;
        step(144);                               // t+145
        sample_tick = 1'b1;
        chk("t5_frame_done", int'(frame_done), 1);
        step(1);                                 // t+146
        sample_tick = 1'b0;
        chk("t5_restart_busy", int'(busy), 1);
        chk("t5_restart_rd", int'(param_rd_en), 1);
        chk("t5_restart_op", int'(op_sel), 0);
        chk("t5_no_overrun", int'(overrun), 0);
        chk("t5_op40_ignored", n_rst_seen - rs0, 0);
        step(145);                               // second frame done + 1

        // ---- Reset mid-frame drops the frame and pending flags ----
        t = mcyc;
        sample_tick = 1'b1;
        step(1);
        sample_tick = 1'b0;
        step(29);                                // t+30
        keyon_set = 1'b1;
        keyon_op  = 6'd3;
        step(1);
        keyon_set = 1'b0;
        step(29);                                // t+60
        reset_n = 1'b0;
        #1;
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_op", int'(op_sel), 0);
        chk("t6_rst_next", int'(next), 0);
        chk("t6_rst_rd", int'(param_rd_en), 0);
        step(2);
        reset_n = 1'b1;
        step(2);
        rs0 = n_rst_seen;
        t   = mcyc;
        sample_tick = 1'b1;
        step(1);
        sample_tick = 1'b0;
        chk("t6_restart_op0", int'(op_sel), 0);
        chk("t6_restart_rd", int'(param_rd_en), 1);
        step(15);                                // t+16
        chk("t6_op3_sel", int'(op_sel), 3);
        chk("t6_op3_pending_lost", int'(restart), 0);
        step(130);                               // t+146
        chk("t6_no_restarts", n_rst_seen - rs0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
